// File: rtl/operand_entry_if.sv
// Bundle of button/operand signals between the front panel and the operand entry block.
interface operand_entry_if #(
  parameter int NUM_OPS = 2,
  parameter int DIGITS  = 4
);
  logic [DIGITS-1:0]           btn;
  logic [2:0]                  sel;
  logic [1:0]                  mode;
  logic [3:0]                  din;
  logic [NUM_OPS*4*DIGITS-1:0] op_out;
  logic                        upd;
  logic                        sel_err;

  modport master (output btn, sel, mode, din, input op_out, upd, sel_err);
  modport slave  (input btn, sel, mode, din, output op_out, upd, sel_err);
endinterface

// File: rtl/operand_entry.sv
// Hex operand entry: debounced per-digit buttons increment, decrement, shift in or
// clear the digits of a selected operand register.
module operand_entry #(
  parameter int               NUM_OPS    = 2,
  parameter int               DIGITS     = 4,
  parameter int               DEB_CYCLES = 16,
  parameter logic [4*DIGITS-1:0] INIT    = 16'h6000
) (
  input  logic            clk,
  input  logic            rst_n,
  operand_entry_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  logic [DIGITS-1:0] sync1_q, sync2_q;
  logic [DIGITS-1:0] deb_q, deb_d;
  logic [DIGITS-1:0] p_q, p_d;
  logic [15:0]       cnt_q [DIGITS];
  logic [15:0]       cnt_d [DIGITS];
  logic [W-1:0]      ops_q [NUM_OPS];
  logic [W-1:0]      ops_d [NUM_OPS];
  logic              upd_q, upd_d;
  logic              err_q, err_d;
  logic              sel_ok;

  // Debounce: level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d = deb_q;
    p_d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if ({1'b0, cnt_q[i]} + 17'd1 == 17'(DEB_CYCLES)) begin
          deb_d[i] = ~deb_q[i];
          p_d[i]   = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign sel_ok = ({1'b0, bus.sel} < 4'(NUM_OPS));

  always_comb begin
    ops_d = ops_q;
    upd_d = 1'b0;
    err_d = 1'b0;
    if (|p_q) begin
      if (!sel_ok) begin
        err_d = 1'b1;
      end else begin
        for (int k = 0; k < NUM_OPS; k++) begin
          if (k == int'(bus.sel)) begin
            unique case (bus.mode)
              2'b00: begin
                for (int i = 0; i < DIGITS; i++)
                  if (p_q[i]) ops_d[k][i*4 +: 4] = ops_q[k][i*4 +: 4] + 4'd1;
                upd_d = 1'b1;
              end
              2'b01: begin
                for (int i = 0; i < DIGITS; i++)
                  if (p_q[i]) ops_d[k][i*4 +: 4] = ops_q[k][i*4 +: 4] - 4'd1;
                upd_d = 1'b1;
              end
              2'b10: begin
                // Only the least-significant button shifts; the others are inert here.
                if (p_q[0]) begin
                  ops_d[k] = {ops_q[k][W-5:0], bus.din};
                  upd_d    = 1'b1;
                end
              end
              default: begin
                ops_d[k] = INIT;
                upd_d    = 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      p_q     <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) cnt_q[i] <= '0;
      for (int k = 0; k < NUM_OPS; k++) ops_q[k] <= INIT;
    end else begin
      sync1_q <= bus.btn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      p_q     <= p_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      for (int i = 0; i < DIGITS; i++) cnt_q[i] <= cnt_d[i];
      for (int k = 0; k < NUM_OPS; k++) ops_q[k] <= ops_d[k];
    end
  end

  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_out
    assign bus.op_out[gi*W +: W] = ops_q[gi];
  end

  assign bus.upd     = upd_q;
  assign bus.sel_err = err_q;
endmodule

// File: tb/tb_operand_entry.sv
// Directed stimulus with a queue scoreboard; a monitor checks every upd/sel_err event.
module tb_operand_entry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  operand_entry_if #(.NUM_OPS(2), .DIGITS(4)) bus ();

  operand_entry #(
    .NUM_OPS(2), .DIGITS(4), .DEB_CYCLES(4), .INIT(16'h6000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [31:0] ops;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic err, input logic [15:0] o0, input logic [15:0] o1);
    sb.push_back({err, o1, o0});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    bus.btn = m;
    cycles(12);
    bus.btn = 4'h0;
    cycles(12);
  endtask

  // Monitor: every output event must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.upd || bus.sel_err)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: upd=%b sel_err=%b op_out=%h", bus.upd, bus.sel_err, bus.op_out);
      end else begin
        e = sb.pop_front();
        chk("event_kind", {30'd0, bus.sel_err, bus.upd}, {30'd0, e.is_err, ~e.is_err});
        chk("op_out", bus.op_out, e.ops);
        $display("event upd=%b sel_err=%b op_out=%h", bus.upd, bus.sel_err, bus.op_out);
      end
    end
  end

  initial begin
    bus.btn  = 4'h0;
    bus.sel  = 3'd0;
    bus.mode = 2'b00;
    bus.din  = 4'h0;
    cycles(3);
    chk("reset_op_out", bus.op_out, 32'h6000_6000);
    chk("reset_upd", {31'd0, bus.upd}, 32'd0);
    chk("reset_sel_err", {31'd0, bus.sel_err}, 32'd0);
    rst_n = 1'b1;
    cycles(3);

    // Bouncing button 0, increment operand 0.
    push(1'b0, 16'h6001, 16'h6000);
    repeat (3) begin
      bus.btn = 4'h1; cycles(2);
      bus.btn = 4'h0; cycles(2);
    end
    press(4'h1);

    // Operand 1: dec digit1 -> 60F0, inc wraps -> 6000, shift 0 -> 0000, dec digit3 -> F000.
    bus.sel = 3'd1; bus.mode = 2'b01;
    push(1'b0, 16'h6001, 16'h60F0); press(4'h2);
    bus.mode = 2'b00;
    push(1'b0, 16'h6001, 16'h6000); press(4'h2);
    bus.mode = 2'b10; bus.din = 4'h0;
    push(1'b0, 16'h6001, 16'h0000); press(4'h1);
    bus.mode = 2'b01;
    push(1'b0, 16'h6001, 16'hF000); press(4'h8);

    // Simultaneous presses on digits 0 and 2.
    bus.sel = 3'd0; bus.mode = 2'b00;
    push(1'b0, 16'h6102, 16'hF000); press(4'h5);

    // Clear then shift in A three times; button 1 is ignored in shift mode.
    bus.mode = 2'b11;
    push(1'b0, 16'h6000, 16'hF000); press(4'h1);
    bus.mode = 2'b10; bus.din = 4'hA;
    push(1'b0, 16'h000A, 16'hF000); press(4'h1);
    press(4'h2);
    push(1'b0, 16'h00AA, 16'hF000); press(4'h1);
    push(1'b0, 16'h0AAA, 16'hF000); press(4'h1);

    // Out-of-range select.
    bus.sel = 3'd5; bus.mode = 2'b00;
    push(1'b1, 16'h0AAA, 16'hF000); press(4'h1);

    // Clears: operand 1, operand 0 with two buttons (one write), operand 1 again (unchanged value).
    bus.mode = 2'b11; bus.sel = 3'd1;
    push(1'b0, 16'h0AAA, 16'h6000); press(4'h4);
    bus.sel = 3'd0;
    push(1'b0, 16'h6000, 16'h6000); press(4'h3);
    bus.sel = 3'd1;
    push(1'b0, 16'h6000, 16'h6000); press(4'h1);

    // Set operand 0 off INIT, then reset mid-debounce with button held.
    bus.sel = 3'd0; bus.mode = 2'b00;
    push(1'b0, 16'h6010, 16'h6000); press(4'h2);
    bus.btn = 4'h1;
    cycles(4);
    rst_n = 1'b0;
    #1;
    chk("midreset_op_out", bus.op_out, 32'h6000_6000);
    cycles(2);
    chk("midreset_op_out_held", bus.op_out, 32'h6000_6000);
    chk("midreset_upd", {31'd0, bus.upd}, 32'd0);
    chk("midreset_sel_err", {31'd0, bus.sel_err}, 32'd0);
    rst_n = 1'b1;
    push(1'b0, 16'h6001, 16'h6000);
    cycles(12);
    bus.btn = 4'h0;
    cycles(12);

    for (int i = 0; i < 50 && sb.size() != 0; i++) cycles(1);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
